data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, meaning number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-004 Port rst  input  1  reset; asynchronous, active-low.
REQ-005 Port req_valid  input  1  requester presents a load/store request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = store (SW), 0 = load (LW).
REQ-008 Port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port resp_valid  output  1  response available.
REQ-011 Port resp_ready  input  1  requester consumes response this cycle.
REQ-012 Port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 Port resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; one request outstanding at most.
REQ-015 req_ready SHALL be 1 exactly when state is IDLE; it is a function of state only.
REQ-016 Acceptance = req_valid & req_ready at a rising edge; req_we, req_addr, req_wdata SHALL be captured then, and later changes of the inputs ignored.
REQ-017 On acceptance: state IDLE->WAIT, latency counter loaded with LATENCY-1.
REQ-018 In WAIT: counter nonzero -> decrement; counter zero -> perform access, state->RESP.
REQ-019 Request accepted at edge N SHALL have resp_valid rise at edge N+LATENCY.
REQ-020 Error condition: captured addr[1:0] != 0, or word index >= DEPTH; SHALL be evaluated at access time.
REQ-021 Store without error: array word written at the access edge; resp_rdata=0, resp_err=0.
REQ-022 Load without error: resp_rdata = array word, registered at the access edge; resp_err=0.
REQ-023 Any error: no array write; resp_rdata=0, resp_err=1.
REQ-024 In RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_valid & resp_ready.
REQ-025 resp_valid & resp_ready at an edge: state->IDLE, resp_valid=0; req_ready=1 in the following cycle.
REQ-026 req_valid asserted outside IDLE SHALL be ignored (not queued).
REQ-027 A load issued after a completed store to the same word SHALL return the stored value.
REQ-028 resp_ready asserted while resp_valid=0 SHALL have no effect.
REQ-029 Width rule: word index uses req_addr[31:2] in full; upper bits are not truncated before the range check.

Reset
REQ-030 rst low SHALL force asynchronously: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 once in IDLE.
REQ-031 Reset during WAIT SHALL drop the transaction; a pending store SHALL not be written.
REQ-032 Reset SHALL not clear array contents; stores completed before reset SHALL remain readable.
REQ-033 Array contents after power-up are undefined; the bench SHALL write before reading.

Structure
REQ-034 State encodings and the default DEPTH/LATENCY values SHALL live in the shared CPU definitions header, alongside the opcode and stage constants.
REQ-035 Storage SHALL be a sub-module data_mem_array: synchronous write, combinational read, DEPTH words; FSM, counter and error checks stay in data_mem_responder.

Verification
REQ-036 Store addr 0x10 data 0xDEADBEEF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, each resp_valid at edge accept+2 (LATENCY=2).
REQ-037 Load addr 0x13 (misaligned) and load addr 0x1000 (index 1024, DEPTH=1024) -> resp_err=1, resp_rdata=0; store to 0x1000 leaves word 0 unchanged.
REQ-038 Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout; req_valid pulses ignored.
REQ-039 Pulse rst low one cycle after a store to 0x20 (data 0x55) is accepted -> no response, req_ready=1 after reset, load 0x20 returns the prior value (0x0 written earlier).
REQ-040 LATENCY=1 with back-to-back requests and resp_ready tied to 1 -> one response every 3 cycles (accept, access, handshake), data in order.
REQ-041 Store addr 0x0FFC data 0x1 and load 0x0FFC -> returns 0x1 (last word, boundary in range).

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared CPU definitions: opcodes, pipeline stages, data-memory defaults and
// the responder's state encoding.
package data_mem_responder_pkg;

    localparam int DMEM_DEPTH_DEFAULT   = 1024;
    localparam int DMEM_LATENCY_DEFAULT = 2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        STG_IF,
        STG_ID,
        STG_EX,
        STG_MEM,
        STG_WB
    } stage_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Full 30-bit word index is compared so high address bits cannot alias
    // onto valid words.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data memory: synchronous write, combinational read.
module data_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed access latency and
// alignment / range error reporting.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        cap_we_reg;
    logic [31:0] cap_addr_reg;
    logic [31:0] cap_wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        access;
    logic        access_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign access_err = dmem_addr_err(cap_addr_reg, DEPTH);
    assign mem_we     = access & cap_we_reg & ~access_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            cap_we_reg    <= 1'b0;
            cap_addr_reg  <= 32'd0;
            cap_wdata_reg <= 32'd0;
            rdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                cap_we_reg    <= req_we;
                cap_addr_reg  <= req_addr;
                cap_wdata_reg <= req_wdata;
            end
            // Stores and faulting requests return zero data.
            if (access) begin
                err_reg   <= access_err;
                rdata_reg <= (cap_we_reg || access_err) ? 32'd0 : mem_rdata;
            end
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cap_addr_reg[AW+1:2]),
        .wdata (cap_wdata_reg),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2 instance for function,
// errors, hold and reset; LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        req_valid_b, req_ready_b, req_we_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        exp_q[$];
    exp_t        exp_q_b[$];
    logic [31:0] model_mem [1024];
    logic [31:0] model_b [4];

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_we     (req_we_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
    endfunction

    // One request on the LATENCY=2 instance; hold = cycles to stall resp_ready.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        exp_t e;
        int   k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the captured request must win.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        e.err   = model_err(addr);
        e.rdata = (we || e.err) ? 32'd0 : model_mem[addr[11:2]];
        if (we && !e.err) model_mem[addr[11:2]] = wdata;
        exp_q.push_back(e);
        check("ready_low_after_accept", 32'(req_ready), 32'd0);

        k = 0;
        while (!resp_valid && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'd2);
        e = exp_q.pop_front();
        check("rdata", resp_rdata, e.rdata);
        check("err", 32'(resp_err), 32'(e.err));
        $display("txn we=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 we, addr, wdata, resp_rdata, resp_err, k);

        for (int h = 0; h < hold; h++) begin
            req_valid = h[0];
            req_addr  = 32'h0000_0040;
            req_we    = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, e.rdata);
            check("hold_err", 32'(resp_err), 32'(e.err));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            check("no_queued_req", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   i, nresp, last_resp, accept_cyc, bad_valid;
        bit   prev_ready;
        exp_t e;

        rst          = 1'b0;
        req_valid    = 1'b0; req_we   = 1'b0; req_addr   = '0; req_wdata   = '0; resp_ready = 1'b0;
        req_valid_b  = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; resp_ready_b = 1'b1;

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 32'h0000_0000, 32'h1234_5678, 0);
        do_req(1'b1, 32'h0000_0020, 32'h0000_0000, 0);
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 0);
        do_req(1'b0, 32'h0000_0013, 32'h0, 0);
        do_req(1'b0, 32'h0000_1000, 32'h0, 0);
        do_req(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 0);
        do_req(1'b1, 32'h8000_0010, 32'hBAD0_BAD0, 0);
        do_req(1'b0, 32'h0000_0000, 32'h0, 0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 5);

        // Reset while a store to 0x20 is in flight.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_rdata", resp_rdata, 32'd0);
        check("arst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bad_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid) bad_valid++;
        end
        check("no_resp_after_rst", 32'(bad_valid), 32'd0);
        do_req(1'b0, 32'h0000_0020, 32'h0, 0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 0);
        do_req(1'b1, 32'h0000_0FFC, 32'h0000_0001, 0);
        do_req(1'b0, 32'h0000_0FFC, 32'h0, 0);

        // LATENCY=1 instance: back-to-back requests, resp_ready tied high.
        i = 0; nresp = 0; last_resp = 0; accept_cyc = 0;
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 32'h0; req_wdata_b = 32'hA000_0000;
        prev_ready = req_ready_b;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (prev_ready && req_valid_b) begin
                e.err   = 1'b0;
                e.rdata = req_we_b ? 32'd0 : model_b[req_addr_b[3:2]];
                if (req_we_b) model_b[req_addr_b[3:2]] = req_wdata_b;
                exp_q_b.push_back(e);
                accept_cyc = cyc;
                i++;
            end
            if (resp_valid_b) begin
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_rdata", resp_rdata_b, e.rdata);
                    check("b_err", 32'(resp_err_b), 32'(e.err));
                    if (nresp > 0) check("b_interval", 32'(cyc - last_resp), 32'd3);
                    else           check("b_first_lat", 32'(cyc - accept_cyc), 32'd1);
                    $display("txn_b #%0d rdata=0x%08h err=%0d cyc=%0d",
                             nresp, resp_rdata_b, resp_err_b, cyc);
                end
                last_resp = cyc;
                nresp++;
            end
            if (i < 8) begin
                req_valid_b = 1'b1;
                req_we_b    = (i < 4);
                req_addr_b  = 32'((i % 4) * 4);
                req_wdata_b = 32'hA000_0000 + 32'(i * 32'h0111);
            end else begin
                req_valid_b = 1'b0;
            end
            prev_ready = req_ready_b;
        end
        check("b_resp_count", 32'(nresp), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
